// File: rtl/ps2_host_tx_ctrl.sv
// PS/2 host-to-device transmit sequencer: clock inhibit, request-to-send, 10-bit
// shift-out on device clock falls, ACK check and final line-idle wait.
module ps2_host_tx_ctrl #(
  parameter int INHIBIT_CYC = 6000,
  parameter int RTS_CYC     = 20,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tx_valid_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_ready_o,
  output logic       done_o,
  output logic       nack_o,
  output logic       tmo_o,
  output logic       rx_hold_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_dat_oe_o
);

  localparam int CNT_M1  = (INHIBIT_CYC > RTS_CYC) ? INHIBIT_CYC : RTS_CYC;
  localparam int CNT_MAX = (CNT_M1 > TIMEOUT_CYC) ? CNT_M1 : TIMEOUT_CYC;
  localparam int CNT_W   = ($clog2(CNT_MAX) < 1) ? 1 : $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYC - 1);
  localparam logic [CNT_W-1:0] RTS_LAST = CNT_W'(RTS_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_bit;
  logic [9:0]       r_frame;
  logic             r_clk_oe, r_dat_oe;
  logic             r_done, r_nack, r_tmo;
  logic             r_clk_s1, r_clk_s2, r_clk_dly;
  logic             r_dat_s1, r_dat_s2;
  logic             w_fall, w_accept;

  // Idle bus level is high, so the synchronizers reset high to avoid a phantom fall.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_clk_s1  <= 1'b1;
      r_clk_s2  <= 1'b1;
      r_clk_dly <= 1'b1;
      r_dat_s1  <= 1'b1;
      r_dat_s2  <= 1'b1;
    end else begin
      r_clk_s1  <= ps2_clk_i;
      r_clk_s2  <= r_clk_s1;
      r_clk_dly <= r_clk_s2;
      r_dat_s1  <= ps2_dat_i;
      r_dat_s2  <= r_dat_s1;
    end
  end

  assign w_fall   = r_clk_dly & ~r_clk_s2;
  assign w_accept = tx_valid_i & tx_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_frame  <= '0;
      r_clk_oe <= 1'b0;
      r_dat_oe <= 1'b0;
      r_done   <= 1'b0;
      r_nack   <= 1'b0;
      r_tmo    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_nack <= 1'b0;
      r_tmo  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_clk_oe <= 1'b0;
          r_dat_oe <= 1'b0;
          if (w_accept) begin
            r_frame  <= {1'b1, ~^tx_data_i, tx_data_i};
            r_cnt    <= '0;
            r_bit    <= '0;
            r_clk_oe <= 1'b1;
            r_state  <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (r_cnt == INH_LAST) begin
            r_cnt    <= '0;
            r_dat_oe <= 1'b1;
            r_state  <= S_RTS;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RTS: begin
          if (r_cnt == RTS_LAST) begin
            r_cnt    <= '0;
            r_bit    <= '0;
            r_clk_oe <= 1'b0;
            r_state  <= S_SEND;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        // Frame shifts out LSB first; the start bit is already on the line from RTS.
        S_SEND: begin
          if (w_fall) begin
            r_cnt    <= '0;
            r_dat_oe <= ~r_frame[0];
            r_frame  <= {1'b0, r_frame[9:1]};
            r_bit    <= r_bit + 1'b1;
            if (r_bit == 4'd9) r_state <= S_ACK;
          end else if (r_cnt == TMO_LAST) begin
            r_tmo    <= 1'b1;
            r_dat_oe <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_ACK: begin
          r_clk_oe <= 1'b0;
          r_dat_oe <= 1'b0;
          if (w_fall) begin
            r_cnt <= '0;
            if (r_dat_s2) begin
              r_nack  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_WAIT_IDLE;
            end
          end else if (r_cnt == TMO_LAST) begin
            r_tmo   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          r_clk_oe <= 1'b0;
          r_dat_oe <= 1'b0;
          if (r_clk_s2 && r_dat_s2) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else if (r_cnt == TMO_LAST) begin
            r_tmo   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_clk_oe <= 1'b0;
          r_dat_oe <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_ready_o   = (r_state == S_IDLE);
  assign rx_hold_o    = (r_state != S_IDLE);
  assign done_o       = r_done;
  assign nack_o       = r_nack;
  assign tmo_o        = r_tmo;
  assign ps2_clk_oe_o = r_clk_oe;
  assign ps2_dat_oe_o = r_dat_oe;

endmodule
